// File: rtl/ysyx_24110015_ifu_prefetch.sv
// Instruction prefetch buffer. It issues in-order fetch requests under a credit limit,
// queues the responses in a FIFO, and discards stale responses after a redirect.
module ysyx_24110015_ifu_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned       PW      = $clog2(DEPTH);
  localparam int unsigned       CW      = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
  logic [ADDR_W-1:0] rsp_pc, rsp_pc_n;
  logic [ADDR_W-1:0] req_addr_n;
  logic              req_valid_n;
  logic [CW-1:0]     outst, outst_n;
  logic [CW-1:0]     drop_cnt, drop_n;
  logic              stale_pend, stale_n;
  logic [CW-1:0]     count, count_n;
  logic [PW-1:0]     wptr, wptr_n, rptr, rptr_n;
  logic              inst_valid_n;
  logic              hs, pop, push, credit;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_lsb_unused;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic              mem_err  [DEPTH];

  assign hs               = req_valid & req_ready;
  assign pop              = inst_valid & inst_ready;
  assign redir_pc         = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redir_lsb_unused = ^redirect_pc[1:0];

  assign inst    = mem_data[rptr];
  assign inst_pc = mem_pc[rptr];
  assign inst_err = mem_err[rptr];

  // Next-state: drop accounting, FIFO pointers, credit-limited request issue
  always_comb begin
    fetch_pc_n   = fetch_pc;
    rsp_pc_n     = rsp_pc;
    req_valid_n  = req_valid;
    req_addr_n   = req_addr;
    outst_n      = outst + CW'(hs) - CW'(rsp_valid);
    drop_n       = drop_cnt;
    stale_n      = stale_pend;
    count_n      = count;
    wptr_n       = wptr;
    rptr_n       = rptr;
    push         = 1'b0;
    credit       = 1'b0;
    inst_valid_n = 1'b0;

    if (redirect_valid) begin
      fetch_pc_n = redir_pc;
      rsp_pc_n   = redir_pc;
      drop_n     = outst + CW'(hs) - CW'(rsp_valid);
      stale_n    = req_valid & ~req_ready;
      count_n    = '0;
      wptr_n     = '0;
      rptr_n     = '0;
    end else begin
      if (rsp_valid) begin
        if (drop_cnt != '0) begin
          drop_n = drop_cnt - 1'b1;
        end else begin
          push     = 1'b1;
          rsp_pc_n = rsp_pc + PC_STEP;
          wptr_n   = wptr + 1'b1;
        end
      end
      // A request held across a redirect is stale once it is finally accepted
      if (hs && stale_pend) begin
        drop_n  = drop_n + 1'b1;
        stale_n = 1'b0;
      end
      if (pop) rptr_n = rptr + 1'b1;
      count_n = count + CW'(push) - CW'(pop);
    end

    credit = ((CW+1)'(count_n) + (CW+1)'(outst_n)) < (CW+1)'(DEPTH);
    if (!req_valid || hs) begin
      req_valid_n = credit;
      if (credit) begin
        req_addr_n = fetch_pc_n;
        fetch_pc_n = fetch_pc_n + PC_STEP;
      end
    end
    inst_valid_n = (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      rsp_pc     <= RESET_PC;
      req_valid  <= 1'b0;
      req_addr   <= '0;
      outst      <= '0;
      drop_cnt   <= '0;
      stale_pend <= 1'b0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      inst_valid <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_pc[i]   <= '0;
        mem_err[i]  <= 1'b0;
      end
    end else begin
      fetch_pc   <= fetch_pc_n;
      rsp_pc     <= rsp_pc_n;
      req_valid  <= req_valid_n;
      req_addr   <= req_addr_n;
      outst      <= outst_n;
      drop_cnt   <= drop_n;
      stale_pend <= stale_n;
      count      <= count_n;
      wptr       <= wptr_n;
      rptr       <= rptr_n;
      inst_valid <= inst_valid_n;
      if (push) begin
        mem_data[wptr] <= rsp_data;
        mem_pc[wptr]   <= rsp_pc;
        mem_err[wptr]  <= rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// Directed bench for the prefetch buffer. It models an in-order 1-cycle memory and
// scoreboards every delivered instruction against the expected pc sequence.
module tb_ysyx_24110015_ifu_prefetch;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct { logic [31:0] addr; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] hs_addrs[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  bit          mem_on, stale_next, first_seen;
  logic [31:0] exp_pc, first_pop_pc, err_addr;

  ysyx_24110015_ifu_prefetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_err(inst_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // One clock: update the model from pre-edge handshakes, then drive the memory response
  task automatic tick();
    bit hs, rf, pp, rd, rh, ih;
    logic [31:0] ra, ipc, idat;
    logic ierr;
    mreq_t m;
    exp_t e;
    hs = req_valid && req_ready;
    rf = rsp_valid;
    pp = inst_valid && inst_ready;
    rd = redirect_valid;
    rh = req_valid && !req_ready && !rst;
    ra = req_addr;
    ih = inst_valid && !inst_ready && !rd && !rst;
    ipc = inst_pc; idat = inst; ierr = inst_err;
    if (rst) begin
      memq.delete();
      expq.delete();
      stale_next = 1'b0;
      exp_pc = RPC;
    end else begin
      if (pp) begin
        if (expq.size() == 0) begin
          chk("pop_unexpected", 32'(inst_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", inst, e.data);
          chk("inst_err", 32'(inst_err), 32'(e.err));
        end
        if (!first_seen) begin
          first_seen = 1'b1;
          first_pop_pc = inst_pc;
        end
      end
      if (rd) begin
        foreach (memq[i]) memq[i].stale = 1'b1;
        expq.delete();
        stale_next = req_valid;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
      if (rf && memq.size() > 0) begin
        m = memq.pop_front();
        if (!m.stale) begin
          chk("req_addr_seq", m.addr, exp_pc);
          e.pc = exp_pc;
          e.data = exp_pc ^ 32'hFFFF_FFFF;
          e.err = (exp_pc == err_addr);
          expq.push_back(e);
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (hs) begin
        hs_cnt++;
        hs_addrs.push_back(req_addr);
        m.addr = req_addr;
        m.stale = stale_next;
        memq.push_back(m);
        stale_next = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (rh) begin
      chk("req_hold_valid", 32'(req_valid), 32'd1);
      chk("req_hold_addr", req_addr, ra);
    end
    if (ih) begin
      chk("inst_hold_valid", 32'(inst_valid), 32'd1);
      chk("inst_hold_pc", inst_pc, ipc);
      chk("inst_hold_data", inst, idat);
      chk("inst_hold_err", 32'(inst_err), 32'(ierr));
    end
    if (!rst && mem_on && memq.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data = memq[0].addr ^ 32'hFFFF_FFFF;
      rsp_err = (memq[0].addr == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data = '0;
      rsp_err = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_on = 1'b1; stale_next = 1'b0; first_seen = 1'b1; first_pop_pc = '0;
    exp_pc = RPC; err_addr = 32'h8000_0004;
    repeat (3) tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", 32'(inst_err), 32'd0);

    // Streaming from reset; the second fetch returns a fault
    rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
    tick();
    chk("first_req_valid", 32'(req_valid), 32'd1);
    chk("first_req_addr", req_addr, RPC);
    tick();
    chk("inst_valid_early", 32'(inst_valid), 32'd0);
    tick();
    chk("first_inst_valid", 32'(inst_valid), 32'd1);
    chk("first_inst_pc", inst_pc, RPC);
    chk("first_inst", inst, ~RPC);
    repeat (12) tick();

    // Credit limit with a stalled consumer
    do_reset();
    inst_ready = 1'b0; req_ready = 1'b1; hs_cnt = 0;
    repeat (12) tick();
    chk("credit_hs", 32'(hs_cnt), 32'd4);
    chk("credit_req_low", 32'(req_valid), 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0; hs_cnt = 0;
    repeat (8) tick();
    chk("credit_one_more", 32'(hs_cnt), 32'd1);
    chk("credit_req_low2", 32'(req_valid), 32'd0);
    inst_ready = 1'b1;
    repeat (10) tick();

    // Redirect with three responses outstanding
    do_reset();
    mem_on = 1'b0; req_ready = 1'b1; inst_ready = 1'b1; hs_cnt = 0;
    for (int i = 0; i < 20 && hs_cnt < 3; i++) tick();
    req_ready = 1'b0;
    chk("outst3_hs", 32'(hs_cnt), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    chk("flush_empty", 32'(inst_valid), 32'd0);
    first_seen = 1'b0; mem_on = 1'b1; req_ready = 1'b1;
    repeat (15) tick();
    chk("redir_first_seen", 32'(first_seen), 32'd1);
    chk("redir_first_pc", first_pop_pc, 32'h8000_0100);

    // Redirect while a request is held by the memory
    do_reset();
    hs_cnt = 0;
    for (int i = 0; i < 20 && hs_cnt < 2; i++) tick();
    req_ready = 1'b0;
    chk("held_valid", 32'(req_valid), 32'd1);
    chk("held_addr", req_addr, 32'h8000_0008);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    chk("held_addr_after", req_addr, 32'h8000_0008);
    hs_addrs.delete(); first_seen = 1'b0; req_ready = 1'b1;
    repeat (10) tick();
    chk("held_hs_cnt", 32'(hs_addrs.size() >= 2), 32'd1);
    if (hs_addrs.size() >= 2) begin
      chk("held_hs0", hs_addrs[0], 32'h8000_0008);
      chk("held_hs1", hs_addrs[1], 32'h8000_2000);
    end
    chk("held_first_pc", first_pop_pc, 32'h8000_2000);

    // Redirect colliding with a response and a pop, then a second redirect
    chk("busy_inst_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
    tick();
    redirect_pc = 32'h8000_4000;
    tick();
    redirect_valid = 1'b0; first_seen = 1'b0;
    repeat (15) tick();
    chk("b2b_first_pc", first_pop_pc, 32'h8000_4000);

    // Address wrap past the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    tick();
    redirect_valid = 1'b0; first_seen = 1'b0;
    repeat (12) tick();
    chk("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);

    req_ready = 1'b0;
    repeat (6) tick();
    chk("idle_outstanding", 32'(dut.outst), 32'd0);
    chk("idle_inst_valid", 32'(inst_valid), 32'd0);
    chk("idle_scoreboard", 32'(expq.size()), 32'd0);

    // Reset in the middle of traffic
    req_ready = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("midrst_req_valid", 32'(req_valid), 32'd0);
    chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_req_addr", req_addr, RPC);
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
